lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store stage between the execute datapath and data memory in the RISC-V core.
- Formats store data with byte enables and issues requests to a variable-latency data memory over a req/gnt/rvalid handshake.
- Extracts and sign- or zero-extends load data, which feeds the "Memory" input of the writeback 4:1 select.
- Holds the core with stall_o while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before aborting with bus_err_o; counter width = $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active-low
mem_read_i  input  1  current instruction is a load
mem_write_i  input  1  current instruction is a store (never asserted together with mem_read_i)
funct3_i  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  input  32  effective address from ALU
store_data_i  input  32  rs2 value
dmem_req_o  output  1  memory request
dmem_we_o  output  1  1 = write
dmem_addr_o  output  32  word-aligned address, {addr[31:2],2'b00}
dmem_be_o  output  4  byte enables
dmem_wdata_o  output  32  lane-replicated store data
dmem_gnt_i  input  1  request accepted this cycle
dmem_rvalid_i  input  1  read data valid (earliest one cycle after gnt)
dmem_rdata_i  input  32  read word
load_data_o  output  32  extended load result to writeback select
stall_o  output  1  hold PC/instruction
misaligned_o  output  1  one-cycle fault, access not issued
bus_err_o  output  1  one-cycle timeout fault

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0; load_data_o=0; timeout counter=0. Takes effect mid-access: request dropped, no completion pulse.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, no access: stall_o=0.
- IDLE, access with illegal funct3 (011/110/111) or misalignment (H/HU: addr[0]=1; W: addr[1:0]!=0):
  - misaligned_o=1 combinationally; stall_o=0; no request; stay IDLE.
- IDLE, legal access:
  - stall_o=1 combinationally.
  - Register addr, funct3, read/write, formatted wdata and be; go REQ.
- REQ:
  - dmem_req_o=1; addr/we/be/wdata stable from registers until gnt.
  - On gnt: store -> DONE; load -> WAIT.
- WAIT: dmem_req_o=0; on rvalid, register extracted/extended data into load_data_o; go DONE.
- DONE: stall_o=0 (core retires the instruction on this edge); go IDLE. DONE never re-triggers on the same instruction.
- stall_o=1 in REQ and WAIT.
- Latency: store with same-cycle gnt = 3 cycles (IDLE, REQ, DONE). Load with gnt in REQ and rvalid the next cycle = 4 cycles.
- load_data_o holds its value until the next load completes; stores do not change it.
- Timeout:
  - Counter clears on IDLE->REQ and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES: bus_err_o=1 for one cycle, go DONE, load_data_o unchanged.
  - gnt/rvalid arriving in the same cycle as the timeout wins (normal completion).
- Store format:
  - SB: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata=d, be=1111.
- Load extract:
  - Byte lane = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passthrough.
- Spurious rvalid outside WAIT is ignored; spurious gnt outside REQ is ignored.

Decomposition:
- Shared package: funct3 load/store encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU) and the FSM state enum, reusable by the decoder.
- One natural sub-module: lsu_align, purely combinational store-format and load-extract logic. The FSM and counter stay in the top module.

Test Plan:
- LW addr=0x100, gnt same cycle as req, rvalid next cycle with rdata=0xDEADBEEF -> stall_o high 3 cycles; load_data_o=0xDEADBEEF in DONE; dmem_be_o=1111.
- LB addr=0x103 and LBU addr=0x103, rdata=0x80FF1234 -> LB gives 0xFFFFFF80, LBU gives 0x00000080; dmem_addr_o=0x100.
- SH addr=0x202, store_data_i=0x0000ABCD, gnt delayed 2 cycles -> dmem_wdata_o=0xABCDABCD, dmem_be_o=1100, req held 3 cycles, stall released in DONE; load_data_o unchanged.
- LW addr=0x101 -> misaligned_o=1 for 1 cycle, dmem_req_o stays 0, stall_o=0.
- Load with TIMEOUT_CYCLES=4, no rvalid -> bus_err_o pulses after 4 cycles in REQ/WAIT, FSM returns to IDLE via DONE.
- rst_n=0 during WAIT -> next cycle state IDLE, stall_o=0, load_data_o=0; a later rvalid is ignored.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared load/store encodings, FSM state and the registered request record
// for the LSU memory stage. The decoder can reuse the funct3 constants.
package lsu_mem_stage_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int XLEN      = NUM_LANES * LANE_W;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  // Everything the bus side needs once the access has left IDLE
  typedef struct packed {
    logic                 we;
    logic [XLEN-1:0]      addr;
    logic [1:0]           lo;
    logic [2:0]           funct3;
    logic [NUM_LANES-1:0] be;
    logic [XLEN-1:0]      wdata;
  } lsu_req_t;

  // Legal encoding and natural alignment for the access size
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      LS_B, LS_BU: access_ok = 1'b1;
      LS_H, LS_HU: access_ok = ~lo[0];
      LS_W:        access_ok = (lo == 2'b00);
      default:     access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational byte-lane formatting: store replication/byte enables on the
// way out, lane extract and sign/zero extension on the way back.
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [1:0]           st_size,
  input  logic [1:0]           st_lo,
  input  logic [XLEN-1:0]      st_data,
  output logic [XLEN-1:0]      st_wdata,
  output logic [NUM_LANES-1:0] st_be,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_lo,
  input  logic [XLEN-1:0]      rdata,
  output logic [XLEN-1:0]      ld_data
);

  logic [NUM_LANES-1:0][LANE_W-1:0] wlane;
  logic [NUM_LANES-1:0][LANE_W-1:0] rlane;
  logic [LANE_W-1:0]                byte_v;
  logic [2*LANE_W-1:0]              half_v;

  // Each lane picks its slice of rs2 and decides whether it is enabled
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LI = 2'(i);
    assign wlane[i] = (st_size == 2'b10) ? st_data[LANE_W*i +: LANE_W] :
                      (st_size == 2'b01) ? st_data[LANE_W*(i%2) +: LANE_W] :
                                           st_data[LANE_W-1:0];
    assign st_be[i] = (st_size == 2'b00) ? (st_lo == LI) :
                      (st_size == 2'b01) ? (st_lo[1] == LI[1]) :
                      (st_size == 2'b10);
  end

  assign st_wdata = wlane;
  assign rlane    = rdata;
  assign byte_v   = rlane[ld_lo];
  assign half_v   = ld_lo[1] ? rdata[XLEN-1:2*LANE_W] : rdata[2*LANE_W-1:0];

  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      LS_B:    ld_data = {{(XLEN-LANE_W){byte_v[LANE_W-1]}}, byte_v};
      LS_BU:   ld_data = {{(XLEN-LANE_W){1'b0}}, byte_v};
      LS_H:    ld_data = {{(XLEN-2*LANE_W){half_v[2*LANE_W-1]}}, half_v};
      LS_HU:   ld_data = {{(XLEN-2*LANE_W){1'b0}}, half_v};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: launches one data-memory access per instruction over
// req/gnt/rvalid, stalls the core meanwhile, and aborts stuck accesses.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state;
  lsu_req_t         req_q;
  logic [CNT_W-1:0] cnt;
  logic             access, legal, start, tmo_hit;
  logic [31:0]      fmt_wdata, ld_ext;
  logic [3:0]       fmt_be;

  assign access  = mem_read_i | mem_write_i;
  assign legal   = access_ok(funct3_i, addr_i[1:0]);
  assign start   = (state == ST_IDLE) & access & legal;
  // The cycle that would make the count reach the limit is the last one allowed
  assign tmo_hit = (cnt >= TMO_M1);

  lsu_align u_align (
    .st_size   (funct3_i[1:0]),
    .st_lo     (addr_i[1:0]),
    .st_data   (store_data_i),
    .st_wdata  (fmt_wdata),
    .st_be     (fmt_be),
    .ld_funct3 (req_q.funct3),
    .ld_lo     (req_q.lo),
    .rdata     (dmem_rdata_i),
    .ld_data   (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      cnt         <= '0;
      load_data_o <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            req_q.we     <= mem_write_i;
            req_q.addr   <= {addr_i[31:2], 2'b00};
            req_q.lo     <= addr_i[1:0];
            req_q.funct3 <= funct3_i;
            req_q.be     <= fmt_be;
            req_q.wdata  <= fmt_wdata;
            cnt          <= '0;
            state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt <= (cnt == TMO) ? cnt : cnt + CNT_W'(1);
          if (dmem_gnt_i) begin
            state <= req_q.we ? ST_DONE : ST_WAIT;
          end else if (tmo_hit) begin
            bus_err_o <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_WAIT: begin
          cnt <= (cnt == TMO) ? cnt : cnt + CNT_W'(1);
          // A response landing on the timeout cycle still completes normally
          if (dmem_rvalid_i) begin
            load_data_o <= ld_ext;
            state       <= ST_DONE;
          end else if (tmo_hit) begin
            bus_err_o <= 1'b1;
            state     <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req_o   = (state == ST_REQ);
  assign dmem_we_o    = req_q.we;
  assign dmem_addr_o  = req_q.addr;
  assign dmem_be_o    = req_q.be;
  assign dmem_wdata_o = req_q.wdata;
  assign stall_o      = start | (state == ST_REQ) | (state == ST_WAIT);
  assign misaligned_o = (state == ST_IDLE) & access & ~legal;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a short timeout limit of 4 cycles.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] load_data_o;
  logic        stall_o, misaligned_o, bus_err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i),
    .load_data_o  (load_data_o),
    .stall_o      (stall_o),
    .misaligned_o (misaligned_o),
    .bus_err_o    (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge, checks happen 1 unit later
  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic clr;
    mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
    addr_i = '0; store_data_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
  endtask

  // Load with gnt in the first REQ cycle and rvalid on the following cycle
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp_ld,
                         input logic [3:0] exp_be);
    mem_read_i = 1'b1; funct3_i = f3; addr_i = a; #1;
    chk({tag, " idle stall"}, 32'(stall_o), 32'd1);
    chk({tag, " idle req"}, 32'(dmem_req_o), 32'd0);
    nxt;
    dmem_gnt_i = 1'b1; #1;
    chk({tag, " req"}, 32'(dmem_req_o), 32'd1);
    chk({tag, " addr"}, dmem_addr_o, {a[31:2], 2'b00});
    chk({tag, " be"}, 32'(dmem_be_o), 32'(exp_be));
    chk({tag, " we"}, 32'(dmem_we_o), 32'd0);
    nxt;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = rd; #1;
    chk({tag, " wait req"}, 32'(dmem_req_o), 32'd0);
    chk({tag, " wait stall"}, 32'(stall_o), 32'd1);
    nxt;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; #1;
    chk({tag, " done stall"}, 32'(stall_o), 32'd0);
    chk({tag, " data"}, load_data_o, exp_ld);
    nxt;
    clr; #1;
    chk({tag, " back idle"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    clr;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    #1;
    chk("rst req", 32'(dmem_req_o), 32'd0);
    chk("rst stall", 32'(stall_o), 32'd0);
    chk("rst ldata", load_data_o, 32'd0);
    chk("rst buserr", 32'(bus_err_o), 32'd0);
    chk("rst misal", 32'(misaligned_o), 32'd0);
    chk("rst be", 32'(dmem_be_o), 32'd0);
    rst_n = 1'b1;
    nxt;

    do_load("LW", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
    nxt;
    do_load("LB", 3'b000, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80, 4'b1000);
    nxt;
    do_load("LBU", 3'b100, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080, 4'b1000);
    nxt;
    do_load("LH", 3'b001, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF, 4'b1100);
    nxt;
    do_load("LHU", 3'b101, 32'h0000_0100, 32'h80FF_9234, 32'h0000_9234, 4'b0011);
    nxt;

    // SH with gnt arriving on the third REQ cycle
    mem_write_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h0000_0202;
    store_data_i = 32'h0000_ABCD; #1;
    chk("SH idle stall", 32'(stall_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      nxt;
      dmem_gnt_i = (i == 2); #1;
      chk("SH req held", 32'(dmem_req_o), 32'd1);
      chk("SH stall", 32'(stall_o), 32'd1);
    end
    chk("SH wdata", dmem_wdata_o, 32'hABCD_ABCD);
    chk("SH be", 32'(dmem_be_o), 32'b1100);
    chk("SH we", 32'(dmem_we_o), 32'd1);
    chk("SH addr", dmem_addr_o, 32'h0000_0200);
    nxt;
    dmem_gnt_i = 1'b0; #1;
    chk("SH done stall", 32'(stall_o), 32'd0);
    chk("SH done req", 32'(dmem_req_o), 32'd0);
    chk("SH ldata kept", load_data_o, 32'h0000_9234);
    nxt;
    clr;
    nxt;

    // SB with same-cycle gnt: IDLE, REQ, DONE
    mem_write_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h0000_0201;
    store_data_i = 32'h1234_5678; #1;
    chk("SB idle stall", 32'(stall_o), 32'd1);
    nxt;
    dmem_gnt_i = 1'b1; #1;
    chk("SB wdata", dmem_wdata_o, 32'h7878_7878);
    chk("SB be", 32'(dmem_be_o), 32'b0010);
    nxt;
    dmem_gnt_i = 1'b0; #1;
    chk("SB done stall", 32'(stall_o), 32'd0);
    nxt;
    clr;
    nxt;

    // Misaligned and illegal encodings are refused in IDLE
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0101; #1;
    chk("LW mis flag", 32'(misaligned_o), 32'd1);
    chk("LW mis stall", 32'(stall_o), 32'd0);
    nxt;
    clr; #1;
    chk("LW mis req", 32'(dmem_req_o), 32'd0);
    chk("LW mis clear", 32'(misaligned_o), 32'd0);
    mem_write_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h0000_0103; #1;
    chk("SH mis flag", 32'(misaligned_o), 32'd1);
    funct3_i = 3'b011; addr_i = 32'h0000_0100; #1;
    chk("f3 011 flag", 32'(misaligned_o), 32'd1);
    nxt;
    clr; #1;
    chk("illegal req", 32'(dmem_req_o), 32'd0);
    nxt;

    // Load that never sees rvalid: 4 cycles in REQ/WAIT then bus error
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0300;
    nxt;
    dmem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt;
      dmem_gnt_i = 1'b0; #1;
      chk("TMO wait stall", 32'(stall_o), 32'd1);
      chk("TMO no err yet", 32'(bus_err_o), 32'd0);
    end
    nxt; #1;
    chk("TMO buserr", 32'(bus_err_o), 32'd1);
    chk("TMO done stall", 32'(stall_o), 32'd0);
    chk("TMO ldata kept", load_data_o, 32'h0000_9234);
    nxt;
    clr; #1;
    chk("TMO err pulse", 32'(bus_err_o), 32'd0);
    chk("TMO idle stall", 32'(stall_o), 32'd0);
    nxt;

    // rvalid on the last allowed cycle beats the timeout
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0304;
    nxt;
    dmem_gnt_i = 1'b1;
    nxt;
    dmem_gnt_i = 1'b0;
    nxt;
    nxt;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    nxt;
    dmem_rvalid_i = 1'b0; #1;
    chk("race buserr", 32'(bus_err_o), 32'd0);
    chk("race ldata", load_data_o, 32'hCAFE_F00D);
    chk("race stall", 32'(stall_o), 32'd0);
    nxt;
    clr;
    nxt;

    // Reset in WAIT abandons the access; later responses are ignored
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0400;
    nxt;
    dmem_gnt_i = 1'b1;
    nxt;
    dmem_gnt_i = 1'b0; #1;
    chk("rstw wait stall", 32'(stall_o), 32'd1);
    clr; rst_n = 1'b0;
    nxt; #1;
    chk("rstw req", 32'(dmem_req_o), 32'd0);
    chk("rstw stall", 32'(stall_o), 32'd0);
    chk("rstw ldata", load_data_o, 32'd0);
    rst_n = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_gnt_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
    nxt;
    clr; #1;
    chk("spur ldata", load_data_o, 32'd0);
    chk("spur req", 32'(dmem_req_o), 32'd0);
    chk("spur stall", 32'(stall_o), 32'd0);
    chk("spur done", 32'(bus_err_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
